// File: rtl/rs_issue.sv
// rs_issue: reservation station with CDB wakeup and per-FU oldest-index issue
module rs_issue #(
  parameter int NUM_ENTRIES = 4,
  parameter int NUM_FU = 3,
  parameter int TAG_W = 5,
  parameter int XLEN = 32,
  localparam int FU_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     squash,
  input  logic                     dispatch_valid,
  input  logic [FU_W-1:0]          dispatch_fu,
  input  logic [TAG_W-1:0]         dispatch_rob_tag,
  input  logic                     dispatch_opa_rdy,
  input  logic                     dispatch_opb_rdy,
  input  logic [TAG_W-1:0]         dispatch_opa_tag,
  input  logic [TAG_W-1:0]         dispatch_opb_tag,
  input  logic [XLEN-1:0]          dispatch_opa_val,
  input  logic [XLEN-1:0]          dispatch_opb_val,
  input  logic                     cdb_valid,
  input  logic [TAG_W-1:0]         cdb_tag,
  input  logic [XLEN-1:0]          cdb_value,
  input  logic [NUM_FU-1:0]        fu_ready,
  output logic                     rs_full,
  output logic [NUM_FU-1:0]        issue_valid,
  output logic [NUM_FU*TAG_W-1:0]  issue_rob_tag,
  output logic [NUM_FU*XLEN-1:0]   issue_opa,
  output logic [NUM_FU*XLEN-1:0]   issue_opb
);
  localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
  typedef enum logic [1:0] {FREE, WAIT, READY} state_t;
  state_t           st      [NUM_ENTRIES];
  logic [FU_W-1:0]  fu      [NUM_ENTRIES];
  logic [TAG_W-1:0] rob_tag [NUM_ENTRIES];
  logic [TAG_W-1:0] a_tag   [NUM_ENTRIES];
  logic [TAG_W-1:0] b_tag   [NUM_ENTRIES];
  logic [XLEN-1:0]  a_val   [NUM_ENTRIES];
  logic [XLEN-1:0]  b_val   [NUM_ENTRIES];
  logic             a_rdy   [NUM_ENTRIES];
  logic             b_rdy   [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] gnt, wake_a, wake_b;
  logic [IDX_W-1:0] alloc;
  logic do_disp, d_a_rdy, d_b_rdy;
  logic [XLEN-1:0] d_a_val, d_b_val;
  // lowest-index free entry; full only counts entries free before the edge
  always_comb begin
    rs_full = 1'b1;
    alloc = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--)
      if (st[i] == FREE) begin
        rs_full = 1'b0;
        alloc = IDX_W'(i);
      end
  end
  // dispatch-time CDB bypass and per-entry operand wakeup matches
  always_comb begin
    do_disp = dispatch_valid && !rs_full && !squash;
    d_a_rdy = dispatch_opa_rdy || (cdb_valid && dispatch_opa_tag == cdb_tag);
    d_b_rdy = dispatch_opb_rdy || (cdb_valid && dispatch_opb_tag == cdb_tag);
    d_a_val = dispatch_opa_rdy ? dispatch_opa_val : cdb_value;
    d_b_val = dispatch_opb_rdy ? dispatch_opb_val : cdb_value;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      wake_a[i] = st[i] == WAIT && !a_rdy[i] && cdb_valid && a_tag[i] == cdb_tag;
      wake_b[i] = st[i] == WAIT && !b_rdy[i] && cdb_valid && b_tag[i] == cdb_tag;
    end
  end
  // per-FU select of the lowest-index READY entry; grant frees it when the FU accepts
  always_comb begin
    issue_valid = '0;
    issue_rob_tag = '0;
    issue_opa = '0;
    issue_opb = '0;
    gnt = '0;
    for (int f = 0; f < NUM_FU; f++)
      for (int i = 0; i < NUM_ENTRIES; i++)
        if (!issue_valid[f] && st[i] == READY && fu[i] == FU_W'(f)) begin
          issue_valid[f] = 1'b1;
          issue_rob_tag[f*TAG_W +: TAG_W] = rob_tag[i];
          issue_opa[f*XLEN +: XLEN] = a_val[i];
          issue_opb[f*XLEN +: XLEN] = b_val[i];
          gnt[i] = fu_ready[f];
        end
  end
  // entry state: squash beats everything; issue, wakeup and allocation touch disjoint states
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        st[i] <= FREE;
        fu[i] <= '0;
        rob_tag[i] <= '0;
        a_tag[i] <= '0;
        b_tag[i] <= '0;
        a_val[i] <= '0;
        b_val[i] <= '0;
        a_rdy[i] <= 1'b0;
        b_rdy[i] <= 1'b0;
      end
    end else if (squash) begin
      for (int i = 0; i < NUM_ENTRIES; i++) st[i] <= FREE;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++)
        if (gnt[i]) st[i] <= FREE;
        else if (st[i] == WAIT) begin
          if (wake_a[i]) begin
            a_rdy[i] <= 1'b1;
            a_val[i] <= cdb_value;
          end
          if (wake_b[i]) begin
            b_rdy[i] <= 1'b1;
            b_val[i] <= cdb_value;
          end
          st[i] <= ((a_rdy[i] || wake_a[i]) && (b_rdy[i] || wake_b[i])) ? READY : WAIT;
        end else if (do_disp && alloc == IDX_W'(i)) begin
          st[i] <= (d_a_rdy && d_b_rdy) ? READY : WAIT;
          fu[i] <= dispatch_fu;
          rob_tag[i] <= dispatch_rob_tag;
          a_tag[i] <= dispatch_opa_tag;
          b_tag[i] <= dispatch_opb_tag;
          a_rdy[i] <= d_a_rdy;
          b_rdy[i] <= d_b_rdy;
          a_val[i] <= d_a_val;
          b_val[i] <= d_b_val;
        end
    end
endmodule

// File: tb/tb_rs_issue.sv
// tb_rs_issue: directed stimulus with a queue scoreboard checked on every issue handshake
module tb_rs_issue;
  logic clock, reset, squash, dispatch_valid;
  logic [1:0] dispatch_fu;
  logic [4:0] dispatch_rob_tag, dispatch_opa_tag, dispatch_opb_tag, cdb_tag;
  logic dispatch_opa_rdy, dispatch_opb_rdy, cdb_valid;
  logic [31:0] dispatch_opa_val, dispatch_opb_val, cdb_value;
  logic [2:0] fu_ready, issue_valid;
  logic rs_full;
  logic [14:0] issue_rob_tag;
  logic [95:0] issue_opa, issue_opb;
  int checks = 0;
  int errors = 0;
  typedef struct {
    int fu;
    logic [4:0] tag;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;
  exp_t q[$];
  rs_issue dut (
    .clock(clock), .reset(reset), .squash(squash),
    .dispatch_valid(dispatch_valid), .dispatch_fu(dispatch_fu), .dispatch_rob_tag(dispatch_rob_tag),
    .dispatch_opa_rdy(dispatch_opa_rdy), .dispatch_opb_rdy(dispatch_opb_rdy),
    .dispatch_opa_tag(dispatch_opa_tag), .dispatch_opb_tag(dispatch_opb_tag),
    .dispatch_opa_val(dispatch_opa_val), .dispatch_opb_val(dispatch_opb_val),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .fu_ready(fu_ready), .rs_full(rs_full), .issue_valid(issue_valid),
    .issue_rob_tag(issue_rob_tag), .issue_opa(issue_opa), .issue_opb(issue_opb)
  );
  initial clock = 1'b0;
  always #5 clock = ~clock;
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, req);
    end
  endtask
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic idle();
    dispatch_valid = 1'b0;
    cdb_valid = 1'b0;
    squash = 1'b0;
  endtask
  task automatic disp(input int f, input int tag, input logic ar, input int at, input int av,
                      input logic br, input int bt, input int bv);
    dispatch_valid = 1'b1;
    dispatch_fu = 2'(f);
    dispatch_rob_tag = 5'(tag);
    dispatch_opa_rdy = ar;
    dispatch_opa_tag = 5'(at);
    dispatch_opa_val = 32'(av);
    dispatch_opb_rdy = br;
    dispatch_opb_tag = 5'(bt);
    dispatch_opb_val = 32'(bv);
  endtask
  task automatic push(input int f, input int tag, input int a, input int b);
    exp_t e;
    e.fu = f;
    e.tag = 5'(tag);
    e.a = 32'(a);
    e.b = 32'(b);
    q.push_back(e);
  endtask
  task automatic cdb(input int tag, input int val);
    cdb_valid = 1'b1;
    cdb_tag = 5'(tag);
    cdb_value = 32'(val);
  endtask
  // monitor: every accepted issue must match the oldest expectation queued for that FU
  initial forever begin
    @(negedge clock);
    for (int f = 0; f < 3; f++)
      if (issue_valid[f] && fu_ready[f]) begin
        int k;
        k = -1;
        for (int j = 0; j < q.size(); j++)
          if (k < 0 && q[j].fu == f) k = j;
        if (k < 0) begin
          checks++;
          errors++;
          $display("FAIL issue_unexpected fu%0d: got tag %0d expected no issue", f, issue_rob_tag[f*5 +: 5]);
        end else begin
          chk($sformatf("issue_tag_fu%0d", f), 64'(issue_rob_tag[f*5 +: 5]), 64'(q[k].tag));
          chk($sformatf("issue_opa_fu%0d", f), 64'(issue_opa[f*32 +: 32]), 64'(q[k].a));
          chk($sformatf("issue_opb_fu%0d", f), 64'(issue_opb[f*32 +: 32]), 64'(q[k].b));
          q.delete(k);
        end
      end
  end
  initial begin
    reset = 1'b1;
    idle();
    disp(0, 0, 0, 0, 0, 0, 0, 0);
    dispatch_valid = 1'b0;
    cdb_tag = '0;
    cdb_value = '0;
    fu_ready = 3'b000;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_full", 64'(rs_full), 0);
    chk("rst_valid", 64'(issue_valid), 0);
    chk("rst_tag", 64'(issue_rob_tag), 0);
    chk("rst_opa", issue_opa[63:0], 0);
    step();
    reset = 1'b0;
    fu_ready = 3'b111;
    disp(1, 7, 1, 0, 5, 1, 0, 9);
    push(1, 7, 5, 9);
    @(negedge clock);
    chk("t1_not_same_cycle", 64'(issue_valid), 0);
    step();
    idle();
    @(negedge clock);
    chk("t1_valid", 64'(issue_valid), 64'h2);
    step();
    @(negedge clock);
    chk("t1_freed", 64'(issue_valid), 0);
    step();
    disp(0, 3, 0, 12, 0, 1, 0, 4);
    push(0, 3, 100, 4);
    step();
    idle();
    @(negedge clock);
    chk("t2_waiting", 64'(issue_valid[0]), 0);
    step();
    cdb(12, 100);
    @(negedge clock);
    chk("t2_no_same_cycle_wake", 64'(issue_valid[0]), 0);
    step();
    idle();
    @(negedge clock);
    chk("t2_woken", 64'(issue_valid[0]), 1);
    step();
    disp(2, 4, 0, 12, 0, 1, 0, 6);
    cdb(12, 55);
    push(2, 4, 55, 6);
    step();
    idle();
    @(negedge clock);
    chk("t3_bypass_valid", 64'(issue_valid), 64'h4);
    step();
    fu_ready = 3'b000;
    for (int i = 0; i < 4; i++) begin
      disp(0, 10 + i, 1, 0, 40 + i, 1, 0, 50 + i);
      push(0, 10 + i, 40 + i, 50 + i);
      if (i == 3) begin
        @(negedge clock);
        chk("t4_not_full_3", 64'(rs_full), 0);
      end
      step();
    end
    disp(1, 20, 1, 0, 1, 1, 0, 2);
    @(negedge clock);
    chk("t4_full", 64'(rs_full), 1);
    step();
    idle();
    fu_ready = 3'b001;
    @(negedge clock);
    chk("t4_still_full", 64'(rs_full), 1);
    step();
    fu_ready = 3'b000;
    @(negedge clock);
    chk("t4_freed_one", 64'(rs_full), 0);
    chk("t4_drop_no_fu1", 64'(issue_valid[1]), 0);
    step();
    fu_ready = 3'b111;
    repeat (3) step();
    @(negedge clock);
    chk("t4_drained", 64'(issue_valid), 0);
    step();
    fu_ready = 3'b000;
    disp(0, 1, 1, 0, 11, 1, 0, 12);
    step();
    disp(2, 21, 1, 0, 21, 1, 0, 121);
    push(2, 21, 21, 121);
    step();
    disp(1, 22, 0, 30, 0, 1, 0, 3);
    step();
    disp(2, 23, 1, 0, 23, 1, 0, 123);
    push(2, 23, 23, 123);
    step();
    idle();
    fu_ready = 3'b100;
    @(negedge clock);
    chk("t5_full", 64'(rs_full), 1);
    chk("t5_first_idx1", 64'(issue_rob_tag[14:10]), 21);
    step();
    @(negedge clock);
    chk("t5_second_idx3", 64'(issue_rob_tag[14:10]), 23);
    step();
    fu_ready = 3'b000;
    squash = 1'b1;
    disp(1, 25, 1, 0, 7, 1, 0, 8);
    @(negedge clock);
    chk("t6_pending_before_squash", 64'(issue_valid), 64'h1);
    step();
    idle();
    @(negedge clock);
    chk("t6_squash_valid", 64'(issue_valid), 0);
    chk("t6_squash_full", 64'(rs_full), 0);
    chk("t6_squash_tag_zero", 64'(issue_rob_tag), 0);
    chk("t6_squash_opa_zero", issue_opa[63:0], 0);
    fu_ready = 3'b111;
    step();
    @(negedge clock);
    chk("t6_dispatch_dropped", 64'(issue_valid), 0);
    step();
    disp(1, 9, 0, 31, 0, 0, 31, 0);
    push(1, 9, 77, 77);
    step();
    idle();
    cdb(31, 77);
    @(negedge clock);
    chk("t7_waiting", 64'(issue_valid), 0);
    step();
    idle();
    @(negedge clock);
    chk("t7_both_woken", 64'(issue_valid), 64'h2);
    step();
    fu_ready = 3'b000;
    disp(0, 14, 1, 0, 3, 1, 0, 4);
    step();
    idle();
    @(negedge clock);
    chk("t8_pending", 64'(issue_valid), 64'h1);
    #2;
    reset = 1'b1;
    #1;
    chk("t8_async_valid", 64'(issue_valid), 0);
    chk("t8_async_tag", 64'(issue_rob_tag), 0);
    chk("t8_async_opb", issue_opb[63:0], 0);
    chk("t8_async_full", 64'(rs_full), 0);
    step();
    reset = 1'b0;
    fu_ready = 3'b111;
    step();
    @(negedge clock);
    chk("t8_no_issue_after_reset", 64'(issue_valid), 0);
    step();
    @(negedge clock);
    chk("queue_empty", 64'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rs_issue.md
RS_ISSUE -- requirements
Module: rs_issue

Interface
REQ-001 Parameter NUM_ENTRIES, default 4, number of reservation-station entries.
REQ-002 Parameter NUM_FU, default 3, number of functional units fed by this block.
REQ-003 Parameter TAG_W, default 5, width of ROB tags.
REQ-004 Parameter XLEN, default 32, width of operand values.
REQ-005 Ports SHALL be:
- clock  in  1  single clock
- reset  in  1  asynchronous, active-high
- squash  in  1  synchronous flush of all entries
- dispatch_valid  in  1  new instruction presented
- dispatch_fu  in  $clog2(NUM_FU)  target FU index
- dispatch_rob_tag  in  TAG_W  destination ROB tag
- dispatch_opa_rdy / dispatch_opb_rdy  in  1 each  operand value valid
- dispatch_opa_tag / dispatch_opb_tag  in  TAG_W each  producer tag when not ready
- dispatch_opa_val / dispatch_opb_val  in  XLEN each  operand value when ready
- cdb_valid  in  1  CDB broadcast valid
- cdb_tag  in  TAG_W  broadcast ROB tag
- cdb_value  in  XLEN  broadcast result
- fu_ready  in  NUM_FU  FU can accept an operation this cycle
- rs_full  out  1  no free entry
- issue_valid  out  NUM_FU  per-FU issue request
- issue_rob_tag  out  NUM_FU*TAG_W  per-FU ROB tag
- issue_opa / issue_opb  out  NUM_FU*XLEN each  per-FU operands

Function
REQ-006 Each entry SHALL be in exactly one state: FREE, WAIT (an operand not ready), READY (both operands ready).
REQ-007 rs_full SHALL equal 1 exactly when no entry is FREE in the current state; entries freed this cycle do not count.
REQ-008 When dispatch_valid=1, rs_full=0 and squash=0, the lowest-index FREE entry SHALL be written at the clock edge; dispatch while rs_full=1 SHALL be dropped with no state change.
REQ-009 Dispatch bypass: if an operand arrives not ready and cdb_valid=1 with cdb_tag equal to its tag in the same cycle, the operand SHALL be captured as ready with cdb_value.
REQ-010 Wakeup: each WAIT entry with an unready operand whose tag equals cdb_tag while cdb_valid=1 SHALL capture cdb_value and mark that operand ready at the edge; both operands may wake on one broadcast.
REQ-011 The entry state SHALL be WAIT→READY at the edge where its last operand becomes ready; a dispatched entry with both operands ready SHALL enter READY directly.
REQ-012 For each FU f, issue_valid[f] SHALL be combinational: 1 when any READY entry targets f; the issued entry SHALL be the lowest-index such entry and slice f of issue_rob_tag/opa/opb SHALL carry its fields (zero when issue_valid[f]=0).
REQ-013 Issue handshake: when issue_valid[f]=1 and fu_ready[f]=1 the selected entry SHALL become FREE at that edge; with fu_ready[f]=0 it SHALL hold unchanged.
REQ-014 An entry woken at edge N SHALL present issue_valid no earlier than the cycle after edge N (wakeup-to-issue latency 1 cycle; dispatch-to-issue latency 1 cycle minimum).
REQ-015 Different FUs SHALL issue independently in the same cycle; at most one entry per FU per cycle.
REQ-016 Simultaneous dispatch and issue SHALL both take effect; dispatch uses only entries FREE before the edge.
REQ-017 squash=1 SHALL set every entry FREE at the edge, overriding dispatch, wakeup and issue in that cycle.

Reset
REQ-018 reset=1 SHALL immediately and asynchronously set all entries FREE and all stored fields to zero.
REQ-019 While in reset: rs_full=0, issue_valid=0, issue_rob_tag/opa/opb=0.
REQ-020 Reset asserted mid-operation SHALL discard all pending entries; no issue SHALL occur until a new dispatch after reset deasserts.

Verification
REQ-021 Dispatch fu=1, tag=7, opa=5, opb=9 both ready, fu_ready=3'b111 -> next cycle issue_valid=3'b010, tag 7, opa 5, opb 9; entry freed after that edge.
REQ-022 Dispatch fu=0, tag=3, opa waiting tag 12, opb=4 ready; cdb_valid with tag 12, value 100 two cycles later -> issue_valid[0]=1 in the cycle after the broadcast with opa=100, opb=4.
REQ-023 Dispatch with opa tag 12 while cdb_valid, tag 12, value 55 in the same cycle -> entry enters READY, issues next cycle with opa=55.
REQ-024 Dispatch 4 entries, fu_ready=0 -> rs_full=1; 5th dispatch dropped; raise fu_ready[f] for one cycle -> one entry freed, rs_full=0 next cycle.
REQ-025 Two READY entries for fu 2 (indices 1 and 3), fu_ready[2]=1 -> index 1 issues first, index 3 the following cycle.
REQ-026 Entries pending, squash=1 for one cycle together with a dispatch -> all entries FREE, issue_valid=0, dispatch dropped; async reset pulse between edges -> outputs zero immediately.
